// File: rtl/pixel_write_ctrl.sv
// rtl/pixel_write_ctrl.sv - ping-pong pixel memory writer with bank-select ownership
//
// Accepts an 8-bit pixel stream over valid/ready and writes each frame into
// the bank selected by buf_select. When a frame completes, the block waits
// until the consumer has released the other bank, then swaps banks.
//
// Optional feature: define STALL_CNT_EN to add the stall_cycles output.
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   pixel_in       incoming pixel
//   pixel_valid    pixel_in valid
//   pixel_sof      start of frame, qualified by pixel_valid
//   pixel_ready    block can accept a pixel this cycle
//   mem_addr       port A write address
//   mem_data       port A write data
//   mem_wren       port A write enable
//   buf_select     bank owned by the writer; consumer reads the other bank
//   frame_done     one-cycle pulse at a bank swap
//   consumer_done  one-cycle pulse, consumer finished reading its bank
//   stall_cycles   (STALL_CNT_EN only) saturating count of stalled valid cycles
module pixel_write_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int FRAME_PIXELS = 1024
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    input  logic              pixel_sof,
    output logic              pixel_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              buf_select,
    output logic              frame_done,
`ifdef STALL_CNT_EN
    output logic [15:0]       stall_cycles,
`endif
    input  logic              consumer_done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        SWAP_WAIT = 2'd2
    } state_t;

    localparam int unsigned     LAST_INT = FRAME_PIXELS - 1;
    localparam logic [ADDR_W:0] LAST_IDX = LAST_INT[ADDR_W:0];
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_next;
    logic [ADDR_W:0]   wr_cnt, wr_cnt_next;
    logic              other_busy, other_busy_next;
    logic              buf_next, done_next, wren_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] data_next;
    logic              accept;

    assign pixel_ready = (state != SWAP_WAIT);
    assign accept      = pixel_valid && pixel_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            wr_cnt     <= '0;
            other_busy <= 1'b0;
            buf_select <= 1'b0;
            frame_done <= 1'b0;
            mem_wren   <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else begin
            state      <= state_next;
            wr_cnt     <= wr_cnt_next;
            other_busy <= other_busy_next;
            buf_select <= buf_next;
            frame_done <= done_next;
            mem_wren   <= wren_next;
            mem_addr   <= addr_next;
            mem_data   <= data_next;
        end
    end

    always_comb begin
        state_next      = state;
        wr_cnt_next     = wr_cnt;
        other_busy_next = other_busy;
        buf_next        = buf_select;
        done_next       = 1'b0;
        wren_next       = 1'b0;
        addr_next       = mem_addr;
        data_next       = mem_data;

        // A release from the consumer only matters outside SWAP_WAIT; inside
        // it, the release triggers the swap, which marks the new bank busy.
        if (consumer_done && state != SWAP_WAIT) begin
            other_busy_next = 1'b0;
        end

        case (state)
            IDLE: begin
                // Non-sof pixels are consumed without a write until a frame starts.
                if (accept && pixel_sof) begin
                    wren_next   = 1'b1;
                    addr_next   = '0;
                    data_next   = pixel_in;
                    wr_cnt_next = CNT_ONE;
                    state_next  = FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    wren_next = 1'b1;
                    data_next = pixel_in;
                    if (pixel_sof) begin
                        // Resync: the partial frame is abandoned silently.
                        addr_next   = '0;
                        wr_cnt_next = CNT_ONE;
                    end else if (wr_cnt == LAST_IDX) begin
                        addr_next   = wr_cnt[ADDR_W-1:0];
                        wr_cnt_next = '0;
                        state_next  = SWAP_WAIT;
                    end else begin
                        addr_next   = wr_cnt[ADDR_W-1:0];
                        wr_cnt_next = wr_cnt + CNT_ONE;
                    end
                end
            end
            SWAP_WAIT: begin
                if (!other_busy || consumer_done) begin
                    buf_next        = ~buf_select;
                    done_next       = 1'b1;
                    other_busy_next = 1'b1;
                    state_next      = FILL;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef STALL_CNT_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cycles <= '0;
        end else if (state == SWAP_WAIT && pixel_valid && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_write_ctrl.sv
// tb/tb_pixel_write_ctrl.sv - scoreboard bench for pixel_write_ctrl
module tb_pixel_write_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 10;
    localparam int FP     = 4;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic [DATA_W-1:0] pixel_in = '0;
    logic              pixel_valid = 1'b0;
    logic              pixel_sof = 1'b0;
    logic              pixel_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              buf_select;
    logic              frame_done;
    logic              consumer_done = 1'b0;
`ifdef STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    pixel_write_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(FP)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .pixel_sof     (pixel_sof),
        .pixel_ready   (pixel_ready),
        .mem_addr      (mem_addr),
        .mem_data      (mem_data),
        .mem_wren      (mem_wren),
        .buf_select    (buf_select),
        .frame_done    (frame_done),
`ifdef STALL_CNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .consumer_done (consumer_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                at;
    } wr_t;

    typedef struct {
        logic bsel;
        int   at;
    } fd_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    wr_t  wq[$];
    fd_t  fq[$];
    chk_t cq[$];

    int tests = 0;
    int fails = 0;

    // Monitor: the only process that compares and counts.
    always @(negedge clk) begin
        while (cq.size() > 0) begin
            chk_t c;
            c = cq.pop_front();
            tests = tests + 1;
            if (c.act !== c.exp) begin
                fails = fails + 1;
                $display("FAIL %s: got 0x%0h expected 0x%0h", c.name, c.act, c.exp);
            end
        end
        if (mem_wren === 1'b1) begin
            tests = tests + 1;
            if (wq.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at cycle %0d, none expected",
                         mem_addr, mem_data, cyc);
            end else begin
                wr_t w;
                w = wq.pop_front();
                if (mem_addr !== w.addr || mem_data !== w.data || cyc != w.at) begin
                    fails = fails + 1;
                    $display("FAIL write: got addr 0x%0h data 0x%0h cycle %0d expected addr 0x%0h data 0x%0h cycle %0d",
                             mem_addr, mem_data, cyc, w.addr, w.data, w.at);
                end
            end
        end
        if (frame_done === 1'b1) begin
            tests = tests + 1;
            if (fq.size() == 0) begin
                fails = fails + 1;
                $display("FAIL unexpected_frame_done: cycle %0d buf_select %0b, none expected",
                         cyc, buf_select);
            end else begin
                fd_t f;
                f = fq.pop_front();
                if (buf_select !== f.bsel || cyc != f.at) begin
                    fails = fails + 1;
                    $display("FAIL frame_done: got buf_select %0b cycle %0d expected buf_select %0b cycle %0d",
                             buf_select, cyc, f.bsel, f.at);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        cq.push_back(c);
    endtask

    // Present one pixel for one cycle; it must be accepted at the next edge.
    task automatic send(input logic [7:0] d, input logic sof, input bit wr, input int addr);
        wr_t w;
        @(negedge clk);
        pixel_in    = d;
        pixel_sof   = sof;
        pixel_valid = 1'b1;
        chk("pixel_ready_on_send", {31'd0, pixel_ready}, 32'd1);
        if (wr) begin
            w.addr = addr[ADDR_W-1:0];
            w.data = d;
            w.at   = cyc + 1;
            wq.push_back(w);
        end
    endtask

    task automatic idle_expect_swap(input logic bsel);
        fd_t f;
        @(negedge clk);
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        f.bsel = bsel;
        f.at   = cyc + 1;
        fq.push_back(f);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_mem_addr"},    {22'd0, mem_addr}, 32'd0);
        chk({tag, "_mem_data"},    {24'd0, mem_data}, 32'd0);
        chk({tag, "_mem_wren"},    {31'd0, mem_wren}, 32'd0);
        chk({tag, "_buf_select"},  {31'd0, buf_select}, 32'd0);
        chk({tag, "_frame_done"},  {31'd0, frame_done}, 32'd0);
        chk({tag, "_pixel_ready"}, {31'd0, pixel_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and quiet period after release.
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("post_release");

        // First frame: no consumer yet, so the swap follows immediately.
        send(8'hAA, 1'b1, 1'b1, 0);
        send(8'hF0, 1'b0, 1'b1, 1);
        send(8'hFF, 1'b0, 1'b1, 2);
        send(8'h00, 1'b0, 1'b1, 3);
        idle_expect_swap(1'b1);
        @(negedge clk);
        chk("hold_mem_addr", {22'd0, mem_addr}, 32'd3);
        chk("hold_mem_data", {24'd0, mem_data}, 32'd0);
        chk("buf_after_frame1", {31'd0, buf_select}, 32'd1);

        // Second frame: consumer still holds its bank, so the writer stalls.
        send(8'h01, 1'b1, 1'b1, 0);
        send(8'h02, 1'b0, 1'b1, 1);
        send(8'h03, 1'b0, 1'b1, 2);
        send(8'h04, 1'b0, 1'b1, 3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            pixel_in    = 8'h55;
            pixel_sof   = 1'b0;
            pixel_valid = 1'b1;
            chk("stall_ready", {31'd0, pixel_ready}, 32'd0);
            chk("stall_buf",   {31'd0, buf_select}, 32'd1);
        end
        begin
            fd_t f;
            @(negedge clk);
            pixel_valid   = 1'b0;
            consumer_done = 1'b1;
            f.bsel = 1'b0;
            f.at   = cyc + 1;
            fq.push_back(f);
        end
        @(negedge clk);
        consumer_done = 1'b0;
        chk("ready_after_swap", {31'd0, pixel_ready}, 32'd1);
        chk("buf_after_swap",   {31'd0, buf_select}, 32'd0);
`ifdef STALL_CNT_EN
        chk("stall_cycles", {16'd0, stall_cycles}, 32'd10);
`endif

        // Consumer releases in FILL, then a resync mid-frame.
        @(negedge clk);
        consumer_done = 1'b1;
        @(negedge clk);
        consumer_done = 1'b0;
        send(8'h10, 1'b1, 1'b1, 0);
        send(8'h11, 1'b0, 1'b1, 1);
        send(8'h22, 1'b0, 1'b1, 2);
        send(8'h33, 1'b1, 1'b1, 0);
        send(8'h44, 1'b0, 1'b1, 1);
        send(8'h55, 1'b0, 1'b1, 2);
        send(8'h66, 1'b0, 1'b1, 3);
        idle_expect_swap(1'b1);
        @(negedge clk);
        chk("buf_after_resync_frame", {31'd0, buf_select}, 32'd1);

        // Reset mid-frame, landing just after the second acceptance edge.
        send(8'hA1, 1'b1, 1'b1, 0);
        send(8'hB2, 1'b0, 1'b0, 1);
        @(posedge clk);
        #1;
        n_rst       = 1'b0;
        pixel_valid = 1'b0;
        pixel_sof   = 1'b0;
        @(negedge clk);
        check_reset_outputs("midframe_reset");
        @(negedge clk);
        n_rst = 1'b1;

        // IDLE drops non-sof pixels, then a full frame from address 0.
        send(8'h5A, 1'b0, 1'b0, 0);
        send(8'h5B, 1'b0, 1'b0, 0);
        send(8'h5C, 1'b0, 1'b0, 0);
        send(8'hC3, 1'b1, 1'b1, 0);
        send(8'hC4, 1'b0, 1'b1, 1);
        send(8'hC5, 1'b0, 1'b1, 2);
        send(8'hC6, 1'b0, 1'b1, 3);
        idle_expect_swap(1'b1);
        repeat (3) @(negedge clk);
        chk("buf_final", {31'd0, buf_select}, 32'd1);
        chk("writes_outstanding", wq.size(), 32'd0);
        chk("swaps_outstanding",  fq.size(), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
